// File: rtl/my_slv_responder.sv
// Slave side of the four-phase async_en/async_rdy handshake: synchronises the request,
// inserts wait states, captures async_data into a FIFO drained through valid/ready.
module my_slv_responder #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     async_en,
   input  logic [DATA_W-1:0]        async_data,
   output logic                     async_rdy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     abort
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   en_s;

   state_e     state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       rdy_q, rdy_d;
   logic       abort_q, abort_d;
   logic       push, pop, full;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [AW:0]       count_q;

   // async_data is deliberately not synchronised: the master holds it stable while async_en=1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_en};
      end
   end

   assign en_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      push    = 1'b0;
      abort_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A full FIFO simply holds the master off; async_rdy stays low.
            if (en_s && !full) begin
               wcnt_d  = 4'(WAIT_CYCLES);
               state_d = StWait;
            end
         end
         StWait: begin
            if (!en_s) begin
               abort_d = 1'b1;
               state_d = StIdle;
            end else if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               push    = 1'b1;
               state_d = StAck;
            end
         end
         StAck: begin
            if (!en_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rdy_d = (state_d == StAck);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         wcnt_q  <= 4'd0;
         rdy_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rdy_q   <= rdy_d;
         abort_q <= abort_d;
      end
   end

   assign full      = (count_q == FULL_LVL);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q] <= async_data;
      end
   end

   assign out_data  = mem[rptr_q];
   assign level     = count_q;
   assign async_rdy = rdy_q;
   assign abort     = abort_q;

endmodule

// File: tb/tb_my_slv_responder.sv
// Bench for my_slv_responder: directed and randomised handshakes checked against a
// queue-based model of the captured-word stream and the handshake latencies.
module tb_my_slv_responder;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned N     = 5;
   localparam int unsigned SYNC  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          async_en;
   logic [DW-1:0] async_data;
   logic          async_rdy;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [2:0]    level;
   logic          abort;

   int total = 0;
   int bad = 0;
   int abort_cnt = 0;
   int lvl_max = 0;

   logic [DW-1:0] model [$];
   logic [DW-1:0] cur_data;
   bit            pend_pop;
   bit            rdy_prev;
   bit            rdy_hit;
   int            abort_base;

   always #5 clk = ~clk;

   my_slv_responder #(
      .DATA_W      (DW),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (N),
      .SYNC_STAGES (SYNC)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .async_en   (async_en),
      .async_data (async_data),
      .async_rdy  (async_rdy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .level      (level),
      .abort      (abort)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mid-cycle model update: apply the previous edge's pop/push, then compare.
   task automatic monitor_step();
      if (rst) begin
         model.delete();
         pend_pop = 1'b0;
         rdy_prev = 1'b0;
         return;
      end
      if (pend_pop) void'(model.pop_front());
      if (async_rdy && !rdy_prev) model.push_back(cur_data);
      rdy_prev = async_rdy;
      if (abort) abort_cnt++;
      check("level", 32'(level), 32'(model.size()));
      check("out_valid", 32'(out_valid), 32'(model.size() != 0));
      if (model.size() != 0) check("out_data", 32'(out_data), 32'(model[0]));
      pend_pop = (model.size() != 0) && out_ready;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor_step();
      @(posedge clk);
      #1;
      if (int'(level) > lvl_max) lvl_max = int'(level);
   endtask

   task automatic req(input logic [DW-1:0] d);
      async_data = d;
      cur_data   = d;
      async_en   = 1'b1;
   endtask

   task automatic wait_rdy(input int exp_lat);
      int lat;
      lat = -1;
      for (int e = 0; e < 100; e++) begin
         tick();
         if (async_rdy) begin
            lat = e;
            break;
         end
      end
      if (exp_lat >= 0) check("rdy_latency", lat, exp_lat);
      else              check("rdy_rise", 32'(async_rdy), 32'd1);
   endtask

   task automatic rel();
      int lat;
      lat = -1;
      async_en = 1'b0;
      for (int e = 0; e < 100; e++) begin
         tick();
         if (!async_rdy) begin
            lat = e;
            break;
         end
      end
      check("rdy_release", lat, 2);
   endtask

   task automatic xfer(input logic [DW-1:0] d, input bit chk_lat);
      req(d);
      wait_rdy(chk_lat ? int'(3 + N) : -1);
      rel();
   endtask

   initial begin
      rst        = 1'b1;
      async_en   = 1'b0;
      async_data = '0;
      out_ready  = 1'b0;
      cur_data   = '0;
      pend_pop   = 1'b0;
      rdy_prev   = 1'b0;
      #2;
      check("reset_rdy", 32'(async_rdy), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_abort", 32'(abort), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Single transfer
      xfer(8'hA5, 1'b1);
      check("single_level", 32'(level), 32'd1);
      check("single_data", 32'(out_data), 32'hA5);
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;

      // Full backpressure
      for (int i = 1; i <= 4; i++) xfer(8'(i), 1'b1);
      check("full_level", 32'(level), 32'd4);
      req(8'h05);
      rdy_hit = 1'b0;
      repeat (12) begin
         tick();
         rdy_hit |= async_rdy;
      end
      check("bp_rdy_held", 32'(rdy_hit), 32'd0);
      check("bp_level", 32'(level), 32'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_rdy(int'(N + 1));
      rel();
      check("bp_refill_level", 32'(level), 32'd4);
      out_ready = 1'b1;
      repeat (6) tick();
      out_ready = 1'b0;
      check("bp_drained", 32'(level), 32'd0);

      // Abort: request withdrawn while still counting wait states
      abort_base = abort_cnt;
      req(8'h77);
      rdy_hit = 1'b0;
      repeat (4) begin
         tick();
         rdy_hit |= async_rdy;
      end
      async_en = 1'b0;
      repeat (12) begin
         tick();
         rdy_hit |= async_rdy;
      end
      check("abort_pulses", abort_cnt - abort_base, 1);
      check("abort_no_rdy", 32'(rdy_hit), 32'd0);
      check("abort_level", 32'(level), 32'd0);

      // Reset in the middle of an acknowledged handshake
      xfer(8'h31, 1'b1);
      req(8'h32);
      wait_rdy(int'(3 + N));
      check("pre_rst_level", 32'(level), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("rst_async_rdy", 32'(async_rdy), 32'd0);
      check("rst_async_level", 32'(level), 32'd0);
      check("rst_async_valid", 32'(out_valid), 32'd0);
      async_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      xfer(8'h44, 1'b1);
      check("post_rst_level", 32'(level), 32'd1);
      check("post_rst_data", 32'(out_data), 32'h44);

      // Wrap-around with continuous draining
      out_ready = 1'b1;
      repeat (3) tick();
      lvl_max = 0;
      for (int i = 0; i < 10; i++) xfer(8'(8'h10 + i), 1'b1);
      repeat (3) tick();
      check("wrap_max_level", lvl_max, 1);
      check("wrap_level", 32'(level), 32'd0);

      // Randomised traffic
      for (int t = 0; t < 24; t++) begin
         logic [DW-1:0] d;
         bit            chk;
         d         = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         if (model.size() >= DEPTH) out_ready = 1'b1;
         chk = (model.size() < DEPTH);
         xfer(d, chk);
         repeat ($urandom_range(0, 3)) tick();
      end

      out_ready = 1'b1;
      repeat (8) tick();
      check("final_level", 32'(level), 32'd0);
      check("abort_total", abort_cnt, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/my_slv_responder.md
# my_slv_responder

Slave-side RTL responder for the my_mst four-phase `async_en`/`async_rdy` handshake. It synchronises the master's request, inserts programmable wait states, and captures `async_data` into an internal FIFO. It then acknowledges with `async_rdy` and releases the handshake once the master drops `async_en`. Captured words drain to downstream logic through a valid/ready port. It sits on the DUT side, opposite the master agent driving `my_mst_interface`.

## Interface

Parameters:
- DATA_W, 8, width of handshake data and FIFO entries
- DEPTH, 4, FIFO entries; power of two, ≥2
- WAIT_CYCLES, 0, extra wait states before capture; 0..15
- SYNC_STAGES, 2, flops in the `async_en` synchroniser; ≥2

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- async_en  in  1  master request; level, four-phase
- async_data  in  DATA_W  master data; master holds it stable while async_en=1
- async_rdy  out  1  slave acknowledge, registered
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  FIFO head (fall-through)
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- abort  out  1  one-cycle pulse on protocol violation

## Operation

- `async_en` passes through a SYNC_STAGES flop chain to produce `en_s`. `async_data` is not synchronised; it is stable by protocol.
- The FSM has three states: IDLE, WAIT and ACK. Wait counter `wcnt` is 4 bits.
  - **IDLE:** `async_rdy`=0. If `en_s`=1 and the FIFO is not full, load `wcnt`=WAIT_CYCLES and go to WAIT. If the FIFO is full, stay in IDLE (backpressure; `async_rdy` stays low).
  - **WAIT:**
    - If `en_s`=0, pulse `abort`, go to IDLE and capture nothing.
    - Else if `wcnt`≠0, decrement `wcnt`.
    - Else push `async_data` into the FIFO, go to ACK, and drive `async_rdy`=1 from the next cycle.
  - **ACK:** `async_rdy`=1. When `en_s`=0, go to IDLE; `async_rdy` drops the following cycle.
- FIFO behaviour:
  - Circular buffer with `$clog2(DEPTH)`-bit pointers that wrap naturally.
  - Push occurs only on the WAIT→ACK transition.
  - Pop occurs when `out_valid` & `out_ready`.
  - Simultaneous push and pop leave `level` unchanged, including when `level`=DEPTH, because pop frees the slot first.
  - Pop when empty is ignored. `out_data` is don't-care when `out_valid`=0.
- Full is checked only at IDLE→WAIT, so a push never targets a full FIFO.
- One capture occurs per handshake. A held `async_en` never causes a second push.

## Timing

- Reset values: `async_rdy`=0, `out_valid`=0, `level`=0, `abort`=0; FSM in IDLE; pointers and synchroniser cleared.
- Reset is asynchronous. Asserting it mid-handshake drops `async_rdy` immediately and discards FIFO contents.
- Latency with `async_en` rising before edge 0 (SYNC_STAGES=2, WAIT_CYCLES=N):
  - `en_s`=1 after edge 1.
  - WAIT is entered at edge 2.
  - Capture happens at edge 3+N.
  - `async_rdy`=1 after edge 3+N.
  - `out_valid`=1 after edge 3+N if the FIFO was empty.
- Release: `async_en` falling before edge k gives `en_s`=0 after edge k+1 and `async_rdy`=0 after edge k+2.
- Minimum handshake period with N=0: 6 cycles.
- `level` and `out_valid` update on the same edge as push or pop. `out_data` changes combinationally with the read pointer.

## Test plan

- **Single transfer:** N=0, `async_data`=0xA5, `out_ready`=0 → `async_rdy` high 3 cycles after request; `level`=1; `out_data`=0xA5. After `async_en` drops, `async_rdy`=0 two cycles later.
- **Wait states:** WAIT_CYCLES=5 → `async_rdy` rises exactly 5 cycles later than with N=0. Capture value is unchanged.
- **Full backpressure:** DEPTH=4, `out_ready`=0, send 0x01..0x04, then request 0x05 → `async_rdy` stays 0 and `level`=4. Pulse `out_ready` for 1 cycle → 0x01 popped, 0x05 captured, `level`=4. Drain yields 0x02,0x03,0x04,0x05.
- **Abort:** WAIT_CYCLES=8, drop `async_en` after 4 cycles in WAIT → one `abort` pulse, no push, `level` unchanged, `async_rdy` never asserted.
- **Reset mid-ACK:** assert `rst` while `async_rdy`=1 with `level`=2 → `async_rdy`=0 and `level`=0 asynchronously. A subsequent handshake works normally.
- **Wrap-around:** 10 back-to-back transfers 0x10..0x19 with `out_ready`=1 → output order matches and `level` never exceeds 1.
